// File: rtl/reduce_gate_checker.sv
// reduce_gate_checker: WIDTH-input reduction gate (AND/OR/XOR and their
// inversions) evaluated twice per operand -- once as a single-cycle parallel
// reduction and once by a bit-serial accumulator -- with the two results
// compared and mismatches tallied in a saturating error counter.
module reduce_gate_checker #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [2:0]       in_mode,
    input  logic             fault_inj,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             par_out,
    output logic             ser_out,
    output logic             mismatch,
    output logic             illegal_mode,
    output logic [CNT_W-1:0] err_count
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FINAL,
        S_DONE
    } state_e;

    typedef enum logic [2:0] {
        M_AND  = 3'd0,
        M_OR   = 3'd1,
        M_XOR  = 3'd2,
        M_NAND = 3'd3,
        M_NOR  = 3'd4,
        M_XNOR = 3'd5,
        M_RSV6 = 3'd6,
        M_RSV7 = 3'd7
    } mode_e;

    // Parallel reference: whole-vector reduction; reserved modes yield 0.
    function automatic logic par_reduce(input logic [WIDTH-1:0] d, input mode_e m);
        case (m)
            M_AND:   return &d;
            M_OR:    return |d;
            M_XOR:   return ^d;
            M_NAND:  return ~&d;
            M_NOR:   return ~|d;
            M_XNOR:  return ~^d;
            default: return 1'b0;
        endcase
    endfunction

    // Starting value for the serial accumulator (identity of the base op).
    function automatic logic acc_identity(input mode_e m);
        case (m)
            M_AND, M_NAND: return 1'b1;
            default:       return 1'b0;
        endcase
    endfunction

    // One serial step: fold a single operand bit into the accumulator.
    function automatic logic acc_step(input logic a, input logic b, input mode_e m);
        case (m)
            M_AND, M_NAND: return a & b;
            M_OR,  M_NOR:  return a | b;
            M_XOR, M_XNOR: return a ^ b;
            default:       return a;
        endcase
    endfunction

    function automatic logic mode_inverts(input mode_e m);
        return (m == M_NAND) || (m == M_NOR) || (m == M_XNOR);
    endfunction

    function automatic logic mode_reserved(input mode_e m);
        return (m == M_RSV6) || (m == M_RSV7);
    endfunction

    state_e           state_q,     state_d;
    logic [WIDTH-1:0] data_q,      data_d;
    mode_e            mode_q,      mode_d;
    logic             fault_q,     fault_d;
    logic [IDX_W-1:0] idx_q,       idx_d;
    logic             acc_q,       acc_d;
    logic             par_q,       par_d;
    logic             ser_q,       ser_d;
    logic             out_valid_q, out_valid_d;
    logic [CNT_W-1:0] err_q,       err_d;

    logic accept;
    logic consume;
    logic mismatch_w;

    // Handshake qualifiers and result-side outputs.
    always_comb begin
        in_ready     = (state_q == S_IDLE) && rst_n;
        accept       = in_valid && in_ready;
        consume      = out_valid_q && out_ready;
        mismatch_w   = out_valid_q && (par_q != ser_q);
        out_valid    = out_valid_q;
        par_out      = par_q;
        ser_out      = ser_q;
        mismatch     = mismatch_w;
        illegal_mode = out_valid_q && mode_reserved(mode_q);
        err_count    = err_q;
    end

    // Next-state and datapath updates for the serial evaluation FSM.
    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        mode_d      = mode_q;
        fault_d     = fault_q;
        idx_d       = idx_q;
        acc_d       = acc_q;
        par_d       = par_q;
        ser_d       = ser_q;
        out_valid_d = out_valid_q;
        err_d       = err_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    data_d  = in_data;
                    mode_d  = mode_e'(in_mode);
                    fault_d = fault_inj;
                    par_d   = par_reduce(in_data, mode_e'(in_mode));
                    acc_d   = acc_identity(mode_e'(in_mode));
                    idx_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                acc_d = acc_step(acc_q, data_q[idx_q], mode_q);
                if (idx_q == IDX_LAST) begin
                    state_d = S_FINAL;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            S_FINAL: begin
                // Reserved modes force 0 on both paths so they never count as errors.
                if (mode_reserved(mode_q)) begin
                    ser_d = 1'b0;
                end else begin
                    ser_d = (acc_q ^ mode_inverts(mode_q)) ^ fault_q;
                end
                out_valid_d = 1'b1;
                state_d     = S_DONE;
            end
            S_DONE: begin
                if (consume) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                    if (mismatch_w && (err_q != '1)) begin
                        err_d = err_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d     = S_IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            data_q      <= '0;
            mode_q      <= M_AND;
            fault_q     <= 1'b0;
            idx_q       <= '0;
            acc_q       <= 1'b0;
            par_q       <= 1'b0;
            ser_q       <= 1'b0;
            out_valid_q <= 1'b0;
            err_q       <= '0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            mode_q      <= mode_d;
            fault_q     <= fault_d;
            idx_q       <= idx_d;
            acc_q       <= acc_d;
            par_q       <= par_d;
            ser_q       <= ser_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
        end
    end

endmodule

// File: tb/tb_reduce_gate_checker.sv
// Directed bench for reduce_gate_checker: three instances (WIDTH=3, WIDTH=8,
// WIDTH=8 with a 2-bit counter) share data/mode/fault/out_ready/reset and each
// has its own in_valid so only the instance under test takes operands.
module tb_reduce_gate_checker;

    localparam int W3 = 0;
    localparam int W8 = 1;
    localparam int C2 = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] in_data;
    logic [2:0] in_mode;
    logic       fault_inj;
    logic       out_ready;
    logic       v_w3, v_w8, v_c2;

    logic       rdy_w3, ov_w3, par_w3, ser_w3, mm_w3, ill_w3;
    logic [7:0] err_w3;
    logic       rdy_w8, ov_w8, par_w8, ser_w8, mm_w8, ill_w8;
    logic [7:0] err_w8;
    logic       rdy_c2, ov_c2, par_c2, ser_c2, mm_c2, ill_c2;
    logic [1:0] err_c2;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    reduce_gate_checker #(.WIDTH(3), .CNT_W(8)) dut_w3 (
        .clk(clk), .rst_n(rst_n), .in_valid(v_w3), .in_ready(rdy_w3),
        .in_data(in_data[2:0]), .in_mode(in_mode), .fault_inj(fault_inj),
        .out_valid(ov_w3), .out_ready(out_ready), .par_out(par_w3),
        .ser_out(ser_w3), .mismatch(mm_w3), .illegal_mode(ill_w3),
        .err_count(err_w3)
    );

    reduce_gate_checker #(.WIDTH(8), .CNT_W(8)) dut_w8 (
        .clk(clk), .rst_n(rst_n), .in_valid(v_w8), .in_ready(rdy_w8),
        .in_data(in_data), .in_mode(in_mode), .fault_inj(fault_inj),
        .out_valid(ov_w8), .out_ready(out_ready), .par_out(par_w8),
        .ser_out(ser_w8), .mismatch(mm_w8), .illegal_mode(ill_w8),
        .err_count(err_w8)
    );

    reduce_gate_checker #(.WIDTH(8), .CNT_W(2)) dut_c2 (
        .clk(clk), .rst_n(rst_n), .in_valid(v_c2), .in_ready(rdy_c2),
        .in_data(in_data), .in_mode(in_mode), .fault_inj(fault_inj),
        .out_valid(ov_c2), .out_ready(out_ready), .par_out(par_c2),
        .ser_out(ser_c2), .mismatch(mm_c2), .illegal_mode(ill_c2),
        .err_count(err_c2)
    );

    function automatic logic f_rdy(input int w);
        case (w)
            W3:      return rdy_w3;
            W8:      return rdy_w8;
            default: return rdy_c2;
        endcase
    endfunction

    function automatic logic f_ov(input int w);
        case (w)
            W3:      return ov_w3;
            W8:      return ov_w8;
            default: return ov_c2;
        endcase
    endfunction

    task automatic set_valid(input int w, input logic v);
        case (w)
            W3:      v_w3 = v;
            W8:      v_w8 = v;
            default: v_c2 = v;
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present an operand and hold in_valid until the accepting edge.
    task automatic accept(input int w, input logic [7:0] d, input logic [2:0] m,
                          input logic f, output int at_cyc);
        bit got;
        got       = 1'b0;
        in_data   = d;
        in_mode   = m;
        fault_inj = f;
        set_valid(w, 1'b1);
        for (int i = 0; i < 40; i++) begin
            if (f_rdy(w)) begin
                got = 1'b1;
                break;
            end
            tick();
        end
        vectors++;
        if (!got) begin
            miscompares++;
            $display("FAIL accept_timeout inst=%0d in_ready=0 required=1", w);
        end
        tick();
        at_cyc = cyc;
        set_valid(w, 1'b0);
    endtask

    // Edges after the accepting edge until out_valid is seen; -1 on timeout.
    task automatic wait_result(input int w, output int lat);
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (f_ov(w)) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        vectors++; if (rdy_w8 !== 1'b0) begin miscompares++; $display("FAIL reset_in_ready got=%b want=0", rdy_w8); end
        vectors++; if (ov_w8 !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got=%b want=0", ov_w8); end
        vectors++; if (par_w8 !== 1'b0 || ser_w8 !== 1'b0) begin miscompares++; $display("FAIL reset_results got=%b%b want=00", par_w8, ser_w8); end
        vectors++; if (mm_w8 !== 1'b0 || ill_w8 !== 1'b0) begin miscompares++; $display("FAIL reset_flags got=%b%b want=00", mm_w8, ill_w8); end
        vectors++; if (err_w8 !== 8'd0 || err_c2 !== 2'd0) begin miscompares++; $display("FAIL reset_err got=%0d/%0d want=0/0", err_w8, err_c2); end
        rst_n = 1'b1;
        #1;
        vectors++; if (rdy_w8 !== 1'b1) begin miscompares++; $display("FAIL idle_in_ready got=%b want=1", rdy_w8); end
    endtask

    task automatic test_exhaustive_w3();
        int t, lat;
        for (int m = 0; m < 6; m++) begin
            for (int d = 0; d < 8; d++) begin
                logic [2:0] dv;
                int         ones;
                logic       base, exp;
                dv   = 3'(d);
                ones = int'(dv[0]) + int'(dv[1]) + int'(dv[2]);
                case (m % 3)
                    0:       base = (ones == 3);
                    1:       base = (ones != 0);
                    default: base = ((ones % 2) == 1);
                endcase
                exp = (m >= 3) ? ~base : base;
                accept(W3, {5'b0, dv}, 3'(m), 1'b0, t);
                wait_result(W3, lat);
                vectors++; if (lat !== 4) begin miscompares++; $display("FAIL w3_latency m=%0d d=%0d got=%0d want=4", m, d, lat); end
                vectors++; if (par_w3 !== exp) begin miscompares++; $display("FAIL w3_par m=%0d d=%0d got=%b want=%b", m, d, par_w3, exp); end
                vectors++; if (ser_w3 !== exp) begin miscompares++; $display("FAIL w3_ser m=%0d d=%0d got=%b want=%b", m, d, ser_w3, exp); end
                vectors++; if (mm_w3 !== 1'b0) begin miscompares++; $display("FAIL w3_mismatch m=%0d d=%0d got=%b want=0", m, d, mm_w3); end
                tick();
            end
        end
        vectors++; if (err_w3 !== 8'd0) begin miscompares++; $display("FAIL w3_err got=%0d want=0", err_w3); end
    endtask

    task automatic test_latency_back_to_back();
        int t0, t1, lat;
        accept(W8, 8'hFF, 3'd0, 1'b0, t0);
        vectors++; if (rdy_w8 !== 1'b0) begin miscompares++; $display("FAIL run_in_ready got=%b want=0", rdy_w8); end
        wait_result(W8, lat);
        vectors++; if (lat !== 9) begin miscompares++; $display("FAIL ff_and_latency got=%0d want=9", lat); end
        vectors++; if (par_w8 !== 1'b1 || ser_w8 !== 1'b1) begin miscompares++; $display("FAIL ff_and_result got=%b%b want=11", par_w8, ser_w8); end
        tick();
        vectors++; if (ov_w8 !== 1'b0 || rdy_w8 !== 1'b1) begin miscompares++; $display("FAIL consume_to_idle got=%b%b want=01", ov_w8, rdy_w8); end
        accept(W8, 8'hA5, 3'd2, 1'b0, t1);
        vectors++; if (t1 - t0 !== 11) begin miscompares++; $display("FAIL accept_spacing got=%0d want=11", t1 - t0); end
        wait_result(W8, lat);
        vectors++; if (lat !== 9) begin miscompares++; $display("FAIL a5_xor_latency got=%0d want=9", lat); end
        vectors++; if (par_w8 !== 1'b0 || ser_w8 !== 1'b0 || mm_w8 !== 1'b0) begin miscompares++; $display("FAIL a5_xor_result got=%b%b%b want=000", par_w8, ser_w8, mm_w8); end
        tick();
    endtask

    task automatic test_backpressure();
        int t, lat;
        out_ready = 1'b0;
        accept(W8, 8'h0F, 3'd1, 1'b0, t);
        wait_result(W8, lat);
        vectors++; if (lat !== 9) begin miscompares++; $display("FAIL bp_latency got=%0d want=9", lat); end
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                in_data = 8'h33;
                in_mode = 3'd0;
                v_w8    = 1'b1;
            end else begin
                v_w8 = 1'b0;
            end
            tick();
            vectors++; if (ov_w8 !== 1'b1 || rdy_w8 !== 1'b0) begin miscompares++; $display("FAIL bp_hold_%0d valid/ready got=%b%b want=10", i, ov_w8, rdy_w8); end
            vectors++; if (par_w8 !== 1'b1 || ser_w8 !== 1'b1 || mm_w8 !== 1'b0) begin miscompares++; $display("FAIL bp_stable_%0d got=%b%b%b want=110", i, par_w8, ser_w8, mm_w8); end
        end
        v_w8      = 1'b0;
        out_ready = 1'b1;
        tick();
        vectors++; if (ov_w8 !== 1'b0 || rdy_w8 !== 1'b1) begin miscompares++; $display("FAIL bp_release got=%b%b want=01", ov_w8, rdy_w8); end
    endtask

    task automatic test_fault();
        int t, lat;
        accept(W8, 8'h00, 3'd1, 1'b1, t);
        wait_result(W8, lat);
        vectors++; if (par_w8 !== 1'b0 || ser_w8 !== 1'b1 || mm_w8 !== 1'b1) begin miscompares++; $display("FAIL fault_result got=%b%b%b want=011", par_w8, ser_w8, mm_w8); end
        tick();
        vectors++; if (err_w8 !== 8'd1) begin miscompares++; $display("FAIL fault_err got=%0d want=1", err_w8); end
        vectors++; if (mm_w8 !== 1'b0) begin miscompares++; $display("FAIL fault_mm_idle got=%b want=0", mm_w8); end
    endtask

    task automatic test_saturate();
        int t, lat;
        for (int k = 1; k <= 4; k++) begin
            logic [1:0] want;
            want = (k < 3) ? 2'(k) : 2'd3;
            accept(C2, 8'h00, 3'd1, 1'b1, t);
            wait_result(C2, lat);
            vectors++; if (mm_c2 !== 1'b1) begin miscompares++; $display("FAIL sat_mm_%0d got=%b want=1", k, mm_c2); end
            tick();
            vectors++; if (err_c2 !== want) begin miscompares++; $display("FAIL sat_err_%0d got=%0d want=%0d", k, err_c2, want); end
        end
    endtask

    task automatic test_illegal();
        int t, lat;
        accept(W8, 8'hFF, 3'd6, 1'b0, t);
        wait_result(W8, lat);
        vectors++; if (lat !== 9) begin miscompares++; $display("FAIL ill6_latency got=%0d want=9", lat); end
        vectors++; if (ill_w8 !== 1'b1) begin miscompares++; $display("FAIL ill6_flag got=%b want=1", ill_w8); end
        vectors++; if (par_w8 !== 1'b0 || ser_w8 !== 1'b0 || mm_w8 !== 1'b0) begin miscompares++; $display("FAIL ill6_result got=%b%b%b want=000", par_w8, ser_w8, mm_w8); end
        tick();
        vectors++; if (err_w8 !== 8'd1 || ill_w8 !== 1'b0) begin miscompares++; $display("FAIL ill6_after err=%0d ill=%b want=1,0", err_w8, ill_w8); end
        accept(W8, 8'h00, 3'd7, 1'b1, t);
        wait_result(W8, lat);
        vectors++; if (ill_w8 !== 1'b1 || ser_w8 !== 1'b0 || mm_w8 !== 1'b0) begin miscompares++; $display("FAIL ill7_result got=%b%b%b want=100", ill_w8, ser_w8, mm_w8); end
        tick();
        vectors++; if (err_w8 !== 8'd1) begin miscompares++; $display("FAIL ill7_err got=%0d want=1", err_w8); end
    endtask

    task automatic test_reset_mid_run();
        int t, lat;
        accept(W8, 8'hFF, 3'd1, 1'b1, t);
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        vectors++; if (rdy_w8 !== 1'b0 || ov_w8 !== 1'b0) begin miscompares++; $display("FAIL midrst_state got=%b%b want=00", rdy_w8, ov_w8); end
        vectors++; if (err_w8 !== 8'd0) begin miscompares++; $display("FAIL midrst_err got=%0d want=0", err_w8); end
        rst_n = 1'b1;
        #1;
        vectors++; if (rdy_w8 !== 1'b1) begin miscompares++; $display("FAIL midrst_idle got=%b want=1", rdy_w8); end
        accept(W8, 8'h80, 3'd3, 1'b0, t);
        wait_result(W8, lat);
        vectors++; if (lat !== 9) begin miscompares++; $display("FAIL midrst_latency got=%0d want=9", lat); end
        vectors++; if (par_w8 !== 1'b1 || ser_w8 !== 1'b1 || mm_w8 !== 1'b0) begin miscompares++; $display("FAIL midrst_nand got=%b%b%b want=110", par_w8, ser_w8, mm_w8); end
        tick();
        vectors++; if (err_w8 !== 8'd0 || ov_w8 !== 1'b0) begin miscompares++; $display("FAIL midrst_final err=%0d ov=%b want=0,0", err_w8, ov_w8); end
    endtask

    initial begin
        v_w3      = 1'b0;
        v_w8      = 1'b0;
        v_c2      = 1'b0;
        in_data   = 8'h00;
        in_mode   = 3'd0;
        fault_inj = 1'b0;
        out_ready = 1'b1;
        rst_n     = 1'b0;
        test_reset();
        test_exhaustive_w3();
        test_latency_back_to_back();
        test_backpressure();
        test_fault();
        test_saturate();
        test_illegal();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/reduce_gate_checker.md
Name: reduce_gate_checker

Overview:
- Parametrised successor to the 3-input AND comparison block: a WIDTH-input reduction gate with six selectable functions.
- Every operand is computed two ways: a single-cycle parallel reduction and a bit-serial FSM that takes one bit per cycle.
- The two results are compared; mismatches are counted in a saturating error counter.
- Used as a self-checking gate-equivalence unit in basic-gate test structures. Operands enter and results leave through valid/ready handshakes.

Parameters:
- WIDTH, 8, number of reduction inputs (2..32).
- CNT_W, 8, width of the error counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  operand valid.
- in_ready  output  1  block can accept an operand.
- in_data  input  WIDTH  operand bits.
- in_mode  input  3  function select: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR; 6 and 7 are reserved.
- fault_inj  input  1  sampled at accept; inverts the serial path's final result (checker self-test).
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- par_out  output  1  parallel-path result.
- ser_out  output  1  serial-path result.
- mismatch  output  1  par_out != ser_out, qualified by out_valid.
- illegal_mode  output  1  latched mode was 6 or 7.
- err_count  output  CNT_W  saturating count of mismatched results consumed.

Behaviour:
- Reset: one clock; synchronous, active-low (rst_n sampled on rising clk edge).
  - While rst_n=0 at an edge: state=IDLE; in_ready=0 on that cycle.
  - out_valid, par_out, ser_out, mismatch, illegal_mode = 0; err_count = 0.
  - Reset mid-operation abandons the current operand. No count update.
- States:
  - IDLE: in_ready=1.
    - Accept when in_valid && in_ready. Latch in_data, in_mode and fault_inj.
    - At the same edge, register par_out = reduction(in_data, mode).
    - Load the serial accumulator with the identity value: 1 for AND/NAND, 0 for OR/NOR/XOR/XNOR.
    - Set idx=0 and go to RUN.
  - RUN: in_ready=0.
    - Each cycle: acc <= acc op data[idx]; idx++.
    - At idx == WIDTH-1, update acc once more and go to FINAL.
  - FINAL: one cycle.
    - ser_out <= acc, inverted for NAND/NOR/XNOR, then XOR fault_inj.
    - out_valid <= 1 and go to DONE.
  - DONE: out_valid=1; par_out, ser_out and mismatch are held stable.
    - On out_valid && out_ready: go to IDLE and clear out_valid next cycle.
    - If mismatch=1, also increment err_count unless it is all-ones (saturates at 2^CNT_W-1).
    - in_ready stays 0 in DONE; a new operand cannot be accepted in the same cycle as result consumption.
- Latency: accept at edge T means out_valid=1 after edge T+WIDTH+1.
  - Minimum spacing between accepts is WIDTH+3 cycles, with out_ready held high.
- Reserved modes 6 and 7: par_out = ser_out = 0, mismatch = 0, illegal_mode = 1 while out_valid.
  - The serial FSM still runs the full WIDTH cycles, so latency is unchanged.
- mismatch is 0 whenever out_valid=0.
- in_data/in_mode changes while not in IDLE have no effect.
- out_ready may be high early. out_ready asserted while out_valid=0 is ignored.

Test Plan:
- Reset then exhaustive test with WIDTH=3 for modes 0..5 over all 8 operands: par_out == ser_out == expected gate value every time, mismatch=0, err_count=0. Example: 3'b111 mode 0 gives 1; 3'b011 mode 0 gives 0; 3'b000 mode 4 gives 1.
- Latency with WIDTH=8: accept 8'hFF mode 0 at edge T → out_valid rises after edge T+9, par_out=ser_out=1. Next, 8'hA5 mode 2 → 0 (even parity).
- Backpressure: hold out_ready=0 for 5 cycles after out_valid rises → outputs stable, in_ready=0, and an in_valid pulse during that time is not accepted. Then raise out_ready → IDLE on the next cycle.
- Fault injection: 8'h00 mode 1 with fault_inj=1 → par_out=0, ser_out=1, mismatch=1. After consumption err_count=1. With CNT_W=2, four faulted ops leave err_count=3 (saturated).
- Illegal mode: in_mode=6 → illegal_mode=1, par_out=ser_out=0, mismatch=0, err_count unchanged.
- Reset mid-run: assert rst_n=0 at cycle 4 of RUN → next cycle state=IDLE, out_valid=0, err_count=0. A fresh operand then completes with normal latency.
